// File: rtl/spi_reg_seq_pkg.sv
// spi_reg_seq shared definitions: SPI frame layout and sequencer states.
// Frame is 24 bits MSB first: rw, 7-bit address, 16-bit data.
package spi_reg_seq_pkg;

  localparam int FRAME_W  = 24;
  localparam int RW_BIT   = 23;
  localparam int ADDR_MSB = 22;
  localparam int ADDR_LSB = 16;
  localparam int DATA_MSB = 15;
  localparam int DATA_LSB = 0;

  localparam logic [4:0] FRAME_NBITS = 5'd23;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_REQ       = 3'd1;
  localparam logic [2:0] ST_WAIT_BUSY = 3'd2;
  localparam logic [2:0] ST_WAIT_DONE = 3'd3;
  localparam logic [2:0] ST_GAP       = 3'd4;
  localparam logic [2:0] ST_RESP      = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE      = ST_IDLE,
    S_REQ       = ST_REQ,
    S_WAIT_BUSY = ST_WAIT_BUSY,
    S_WAIT_DONE = ST_WAIT_DONE,
    S_GAP       = ST_GAP,
    S_RESP      = ST_RESP
  } state_e;

  // Reads carry no payload, so the data field is zeroed.
  function automatic logic [FRAME_W-1:0] pack_frame(
    input logic        rw,
    input logic [6:0]  addr,
    input logic [15:0] wdata
  );
    return {rw, addr, rw ? 16'h0000 : wdata};
  endfunction

endpackage

// File: rtl/spi_reg_seq_fifo.sv
// spi_cmd_fifo: synchronous command FIFO with full/empty flags and count.
// Push while full is accepted when a pop happens in the same cycle.
module spi_cmd_fifo #(
  parameter int W     = 24,
  parameter int DEPTH = 4
) (
  input  logic                       clk_in,
  input  logic                       nrst,
  input  logic                       push_i,
  input  logic [W-1:0]               wdata_i,
  input  logic                       pop_i,
  output logic [W-1:0]               rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == FULL_CNT);
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rd_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = wr_q + 1'b1;
    if (do_pop)  rd_d = rd_q + 1'b1;
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_in or negedge nrst) begin
    if (!nrst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end

endmodule

// File: rtl/spi_reg_seq.sv
// spi_reg_seq: queues host register commands, runs one SPI frame each
// through the master and returns one response per command, in order.
module spi_reg_seq
  import spi_reg_seq_pkg::*;
#(
  parameter int ADDR_W     = 7,
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CYCLES = 8
) (
  input  logic              clk_in,
  input  logic              nrst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_rw,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_rw,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              m_request,
  output logic [4:0]        m_nbits,
  output logic [31:0]       m_mosi_data,
  input  logic [31:0]       m_miso_data,
  input  logic              m_ready
);

  if (ADDR_W != 7 || DATA_W != 16) begin : g_fmt_chk
    $error("spi_reg_seq: frame format requires ADDR_W=7 and DATA_W=16");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_chk
    $error("spi_reg_seq: FIFO_DEPTH must be a power of two >= 2");
  end
  if (GAP_CYCLES < 0 || GAP_CYCLES > 255) begin : g_gap_chk
    $error("spi_reg_seq: GAP_CYCLES must be in 0..255");
  end

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_e               state_q, state_d;
  logic [FRAME_W-1:0]   hold_q, hold_d;
  logic [7:0]           gap_q, gap_d;
  logic                 rsp_rw_q, rsp_rw_d;
  logic [ADDR_W-1:0]    rsp_addr_q, rsp_addr_d;
  logic [DATA_W-1:0]    rsp_rdata_q, rsp_rdata_d;

  logic                 fifo_push, fifo_pop;
  logic                 fifo_full, fifo_empty;
  logic [FRAME_W-1:0]   fifo_wdata, fifo_rdata;
  logic [CW-1:0]        fifo_cnt;

  // Upper miso bits hold stale shift data; fill level is informational.
  logic unused_bits;
  assign unused_bits = ^{m_miso_data[31:16], fifo_cnt};

  assign fifo_push  = cmd_valid && cmd_ready;
  assign fifo_wdata = pack_frame(cmd_rw, cmd_addr, cmd_wdata);

  spi_cmd_fifo #(
    .W     (FRAME_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_in  (clk_in),
    .nrst    (nrst),
    .push_i  (fifo_push),
    .wdata_i (fifo_wdata),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  assign cmd_ready   = !fifo_full;
  assign rsp_valid   = (state_q == S_RESP);
  assign rsp_rw      = rsp_rw_q;
  assign rsp_addr    = rsp_addr_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign m_request   = (state_q == S_REQ);
  assign m_nbits     = FRAME_NBITS;
  assign m_mosi_data = {8'h00, hold_q};

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    gap_d       = gap_q;
    rsp_rw_d    = rsp_rw_q;
    rsp_addr_d  = rsp_addr_q;
    rsp_rdata_d = rsp_rdata_q;
    fifo_pop    = 1'b0;

    if (gap_q != 8'd0) gap_d = gap_q - 8'd1;

    unique case (state_q)
      S_IDLE: begin
        if (gap_q != 8'd0) begin
          state_d = S_GAP;
        end else if (!fifo_empty) begin
          fifo_pop = 1'b1;
          hold_d   = fifo_rdata;
          state_d  = S_REQ;
        end
      end
      S_GAP: begin
        if (gap_q <= 8'd1) state_d = S_IDLE;
      end
      S_REQ: begin
        state_d = S_WAIT_BUSY;
      end
      // Ready is still high from the previous frame until the master starts.
      S_WAIT_BUSY: begin
        if (!m_ready) state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (m_ready) begin
          rsp_rw_d    = hold_q[RW_BIT];
          rsp_addr_d  = hold_q[ADDR_MSB:ADDR_LSB];
          rsp_rdata_d = hold_q[RW_BIT] ? m_miso_data[DATA_MSB:DATA_LSB] : '0;
          gap_d       = 8'(GAP_CYCLES);
          state_d     = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge nrst) begin
    if (!nrst) begin
      state_q     <= S_IDLE;
      hold_q      <= '0;
      gap_q       <= '0;
      rsp_rw_q    <= 1'b0;
      rsp_addr_q  <= '0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      gap_q       <= gap_d;
      rsp_rw_q    <= rsp_rw_d;
      rsp_addr_q  <= rsp_addr_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

endmodule

// File: tb/tb_spi_reg_seq.sv
// tb_spi_reg_seq: scoreboard bench with a cycle-level SPI master/slave model.
// Frames and responses are predicted at push time and compared on output.
module tb_spi_reg_seq;

  localparam int GAP       = 8;
  localparam int FRAME_LEN = 10;

  logic        clk_in = 1'b0;
  logic        nrst;
  logic        cmd_valid, cmd_ready, cmd_rw;
  logic [6:0]  cmd_addr;
  logic [15:0] cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_rw;
  logic [6:0]  rsp_addr;
  logic [15:0] rsp_rdata;
  logic        m_request;
  logic [4:0]  m_nbits;
  logic [31:0] m_mosi_data, m_miso_data;
  logic        m_ready;

  always #5 clk_in = ~clk_in;

  spi_reg_seq #(
    .ADDR_W     (7),
    .DATA_W     (16),
    .FIFO_DEPTH (4),
    .GAP_CYCLES (GAP)
  ) dut (
    .clk_in      (clk_in),
    .nrst        (nrst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_rw      (cmd_rw),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rw      (rsp_rw),
    .rsp_addr    (rsp_addr),
    .rsp_rdata   (rsp_rdata),
    .m_request   (m_request),
    .m_nbits     (m_nbits),
    .m_mosi_data (m_mosi_data),
    .m_miso_data (m_miso_data),
    .m_ready     (m_ready)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  logic [31:0] exp_frm_q [$];
  logic [23:0] exp_rsp_q [$];

  function automatic logic [15:0] slave_rd(input logic [6:0] a);
    return (a == 7'h05) ? 16'hA55A : ({a, 9'h0C3} ^ 16'h1234);
  endfunction

  int busy_dly  = 1;
  bit chk_lat   = 1'b0;
  int push_cyc  = 0;
  int ready_cyc = -100;
  bit have_rdy  = 1'b0;
  int req_cnt   = 0;
  int rsp_cnt   = 0;
  int mst       = 0;

  // Command push monitor: predict frame and response.
  initial begin
    forever begin
      @(negedge clk_in);
      if (nrst && cmd_valid && cmd_ready) begin
        exp_frm_q.push_back({8'h00, cmd_rw, cmd_addr,
                             cmd_rw ? 16'h0000 : cmd_wdata});
        exp_rsp_q.push_back({cmd_rw, cmd_addr,
                             cmd_rw ? slave_rd(cmd_addr) : 16'h0000});
        push_cyc = cyc;
      end
    end
  end

  // SPI master + slave model.
  initial begin
    int          mcnt;
    bit          first;
    logic [31:0] cur;
    m_ready     = 1'b1;
    m_miso_data = 32'hFFFF_DEAD;
    mcnt  = 0;
    first = 1'b0;
    cur   = '0;
    forever begin
      @(posedge clk_in);
      #1;
      if (!nrst) begin
        mst     = 0;
        m_ready = 1'b1;
      end else begin
        case (mst)
          0: if (m_request) begin
            req_cnt++;
            cur = m_mosi_data;
            if (exp_frm_q.size() == 0)
              chk("req_spurious", 32'd1, 32'd0);
            else
              chk("frame", m_mosi_data, exp_frm_q.pop_front());
            chk("nbits", 32'(m_nbits), 32'd23);
            chk("req_no_rsp", 32'(rsp_valid), 32'd0);
            if (have_rdy)
              chk("gap", 32'((cyc - ready_cyc) >= GAP), 32'd1);
            if (chk_lat) begin
              chk("req_latency", 32'(cyc - push_cyc), 32'd2);
              chk_lat = 1'b0;
            end
            m_miso_data = {8'hFF, 8'h00, 16'hDEAD};
            mcnt  = busy_dly;
            first = 1'b1;
            mst   = 1;
          end
          1: begin
            if (first) begin
              chk("req_pulse", 32'(m_request), 32'd0);
              first = 1'b0;
            end
            if (mcnt <= 1) begin
              m_ready = 1'b0;
              mcnt    = FRAME_LEN;
              mst     = 2;
            end else mcnt--;
          end
          default: begin
            if (mcnt <= 1) begin
              m_miso_data = {8'hFF, 8'($urandom), slave_rd(cur[22:16])};
              m_ready     = 1'b1;
              ready_cyc   = cyc;
              have_rdy    = 1'b1;
              mst         = 0;
            end else mcnt--;
          end
        endcase
      end
    end
  end

  // Response monitor: latency, stability under stall, in-order data.
  initial begin
    bit          stall;
    logic [23:0] held;
    stall = 1'b0;
    held  = '0;
    forever begin
      @(negedge clk_in);
      if (!nrst) begin
        stall = 1'b0;
      end else begin
        if (stall)
          chk("rsp_stable", {7'd0, rsp_valid, rsp_rw, rsp_addr, rsp_rdata},
              {7'd0, 1'b1, held});
        else if (rsp_valid)
          chk("rsp_latency", 32'(cyc - ready_cyc), 32'd1);
        if (rsp_valid && rsp_ready) begin
          rsp_cnt++;
          if (exp_rsp_q.size() == 0)
            chk("rsp_spurious", 32'd1, 32'd0);
          else
            chk("rsp", {8'd0, rsp_rw, rsp_addr, rsp_rdata},
                {8'd0, exp_rsp_q.pop_front()});
        end
        stall = rsp_valid && !rsp_ready;
        held  = {rsp_rw, rsp_addr, rsp_rdata};
      end
    end
  end

  task automatic send(input logic rw, input logic [6:0] a,
                      input logic [15:0] d);
    int   n;
    logic ok;
    n         = 0;
    cmd_valid = 1'b1;
    cmd_rw    = rw;
    cmd_addr  = a;
    cmd_wdata = d;
    do begin
      @(negedge clk_in);
      ok = cmd_ready;
      @(posedge clk_in);
      #1;
      n++;
    end while (!ok && n < 400);
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_drain(input int limit);
    int n;
    n = 0;
    while ((exp_rsp_q.size() != 0 || mst != 0) && n < limit) begin
      @(posedge clk_in);
      #1;
      n++;
    end
    chk("drain", 32'(exp_rsp_q.size()), 32'd0);
    repeat (GAP + 2) @(posedge clk_in);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_rw"}, 32'(rsp_rw), 32'd0);
    chk({tag, "_rsp_addr"}, 32'(rsp_addr), 32'd0);
    chk({tag, "_rsp_rdata"}, 32'(rsp_rdata), 32'd0);
    chk({tag, "_m_request"}, 32'(m_request), 32'd0);
    chk({tag, "_m_mosi"}, m_mosi_data, 32'd0);
    chk({tag, "_m_nbits"}, 32'(m_nbits), 32'd23);
  endtask

  initial begin
    int c0, r0, q0, n;
    nrst      = 1'b0;
    cmd_valid = 1'b0;
    cmd_rw    = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk_in);
    #1;
    chk_reset("rst");
    nrst = 1'b1;
    @(posedge clk_in);
    #1;

    // single write, then a read with stale upper miso bits
    chk_lat = 1'b1;
    send(1'b0, 7'h12, 16'hBEEF);
    wait_drain(300);
    send(1'b1, 7'h05, 16'h1234);
    wait_drain(300);

    // five back-to-back pushes into a depth-4 FIFO
    c0 = cyc;
    for (int i = 0; i < 5; i++)
      send(1'(i), 7'h20 + 7'(i), 16'h1000 * 16'(i) + 16'(i));
    chk("b2b_cycles", 32'(cyc - c0), 32'd5);
    @(negedge clk_in);
    chk("b2b_full", 32'(cmd_ready), 32'd0);
    @(posedge clk_in);
    #1;
    wait_drain(1500);

    // host backpressure
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      send(1'(~i), 7'h50 + 7'(i), 16'hC000 + 16'(i));
    n = 0;
    while (!rsp_valid && n < 300) begin
      @(posedge clk_in);
      #1;
      n++;
    end
    chk("bp_rsp_seen", 32'(rsp_valid), 32'd1);
    r0 = req_cnt;
    repeat (50) @(posedge clk_in);
    #1;
    chk("bp_no_req", 32'(req_cnt - r0), 32'd0);
    chk("bp_full", 32'(cmd_ready), 32'd0);
    rsp_ready = 1'b1;
    wait_drain(1500);

    // master ready slow to drop after request
    busy_dly = 3;
    send(1'b1, 7'h33, 16'h0000);
    wait_drain(300);
    send(1'b0, 7'h34, 16'h5678);
    wait_drain(300);
    busy_dly = 1;

    // reset mid-frame with commands still queued
    send(1'b0, 7'h40, 16'h1111);
    send(1'b1, 7'h41, 16'h0000);
    send(1'b0, 7'h42, 16'h2222);
    n = 0;
    while (mst != 2 && n < 100) begin
      @(posedge clk_in);
      #1;
      n++;
    end
    chk("rst_mid_busy", 32'(mst), 32'd2);
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    #2;
    nrst = 1'b0;
    #1;
    chk_reset("rst_mid");
    exp_rsp_q.delete();
    exp_frm_q.delete();
    repeat (2) @(posedge clk_in);
    #1;
    nrst = 1'b1;
    r0 = rsp_cnt;
    q0 = req_cnt;
    repeat (40) @(posedge clk_in);
    #1;
    chk("rst_no_rsp", 32'(rsp_cnt - r0), 32'd0);
    chk("rst_no_req", 32'(req_cnt - q0), 32'd0);

    // recovery after reset
    chk_lat = 1'b1;
    send(1'b1, 7'h7F, 16'h0000);
    wait_drain(300);
    chk("sb_frames_empty", 32'(exp_frm_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
